// File: rtl/alu_operand_stage_pkg.sv
// Shared types and constants for the ALU issue/writeback stage.
// Widths, opcodes, operand-source selection and the writeback record.
package alu_operand_stage_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned OPW   = 5;

  localparam logic [OPW-1:0] ALU_ADD   = 5'd0;
  localparam logic [OPW-1:0] ALU_SUB   = 5'd1;
  localparam logic [OPW-1:0] ALU_AND   = 5'd2;
  localparam logic [OPW-1:0] ALU_OR    = 5'd3;
  localparam logic [OPW-1:0] ALU_XOR   = 5'd4;
  localparam logic [OPW-1:0] ALU_PASSB = 5'd5;

  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_ALU,
    SRC_RET,
    SRC_RF,
    SRC_IMM
  } src_e;

  typedef struct packed {
    logic             valid;
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
  } wb_t;

  // Youngest in-flight producer wins; r0 is hardwired to zero.
  function automatic src_e fwd_src(input logic [AW-1:0] s,
                                   input logic          iss_valid,
                                   input logic [AW-1:0] iss_rd,
                                   input logic          ret_valid,
                                   input logic [AW-1:0] ret_rd);
    if (s == '0)                        return SRC_ZERO;
    else if (iss_valid && iss_rd == s)  return SRC_ALU;
    else if (ret_valid && ret_rd == s)  return SRC_RET;
    else                                return SRC_RF;
  endfunction

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// NREGS x WIDTH register file: two async read ports, one sync write port.
// Entry 0 is never written; read-during-write returns the old contents.
module alu_operand_stage_reg_file
  import alu_operand_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue/writeback stage around a combinational ALU: operand fetch with
// forwarding, registered ALU inputs, result capture and retire with backpressure.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic             in_imm_sel,
  input  logic [WIDTH-1:0] in_imm,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_z,
  output logic             ret_valid,
  input  logic             ret_ready,
  output logic [AW-1:0]    ret_rd,
  output logic [WIDTH-1:0] ret_data
);

  logic             hold;
  logic             accept;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  wb_t              wb;
  src_e             src_x;
  src_e             src_y;
  logic [WIDTH-1:0] rf_x;
  logic [WIDTH-1:0] rf_y;
  logic [WIDTH-1:0] opnd_x;
  logic [WIDTH-1:0] opnd_y;

  assign hold     = wb.valid & ~ret_ready;
  assign in_ready = ~hold;
  assign accept   = in_valid & in_ready;

  assign ret_valid = wb.valid;
  assign ret_rd    = wb.rd;
  assign ret_data  = wb.data;

  alu_operand_stage_reg_file u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (in_rs),
    .rdata_a (rf_x),
    .raddr_b (in_rt),
    .rdata_b (rf_y),
    .we      (wb.valid & ret_ready),
    .waddr   (wb.rd),
    .wdata   (wb.data)
  );

  // Immediate select short-circuits the rt comparators entirely.
  always_comb begin
    src_x = fwd_src(in_rs, iss_valid, iss_rd, wb.valid, wb.rd);
    src_y = SRC_IMM;
    if (!in_imm_sel) src_y = fwd_src(in_rt, iss_valid, iss_rd, wb.valid, wb.rd);
  end

  always_comb begin
    opnd_x = rf_x;
    case (src_x)
      SRC_ZERO: opnd_x = '0;
      SRC_ALU:  opnd_x = alu_z;
      SRC_RET:  opnd_x = wb.data;
      default:  opnd_x = rf_x;
    endcase
    opnd_y = rf_y;
    case (src_y)
      SRC_ZERO: opnd_y = '0;
      SRC_ALU:  opnd_y = alu_z;
      SRC_RET:  opnd_y = wb.data;
      SRC_IMM:  opnd_y = in_imm;
      default:  opnd_y = rf_y;
    endcase
  end

  // I and W advance together; both freeze while retire is backpressured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_valid <= 1'b0;
      iss_rd    <= '0;
      alu_op    <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      wb        <= '0;
    end else if (!hold) begin
      wb        <= '{valid: iss_valid, rd: iss_rd, data: alu_z};
      iss_valid <= accept;
      if (accept) begin
        iss_rd <= in_rd;
        alu_op <= in_op;
        alu_x  <= opnd_x;
        alu_y  <= opnd_y;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: supplies the ALU, keeps an in-order architectural
// model of the register file, and checks operands and retired results.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_op;
  logic [AW-1:0]    in_rd;
  logic [AW-1:0]    in_rs;
  logic [AW-1:0]    in_rt;
  logic             in_imm_sel;
  logic [WIDTH-1:0] in_imm;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] alu_z;
  logic             ret_valid;
  logic             ret_ready;
  logic [AW-1:0]    ret_rd;
  logic [WIDTH-1:0] ret_data;

  int tests = 0;
  int fails = 0;

  alu_operand_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_imm_sel (in_imm_sel),
    .in_imm     (in_imm),
    .alu_op     (alu_op),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_z      (alu_z),
    .ret_valid  (ret_valid),
    .ret_ready  (ret_ready),
    .ret_rd     (ret_rd),
    .ret_data   (ret_data)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_alu(input logic [OPW-1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_PASSB: return b;
      default:   return '0;
    endcase
  endfunction

  assign alu_z = ref_alu(alu_op, alu_x, alu_y);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
  } obs_t;

  // Architectural model: ops take effect in program order at acceptance.
  logic [WIDTH-1:0] mreg [NREGS];
  obs_t             exp_q[$];
  obs_t             got_q[$];
  logic [2*WIDTH-1:0] xy_log[$];
  logic             pend_xy = 1'b0;
  logic [WIDTH-1:0] px, py;
  logic             hold_seen = 1'b0;
  logic [AW-1:0]    h_rd;
  logic [WIDTH-1:0] h_data, h_x, h_y;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mreg[i] = '0;
      exp_q.delete();
      pend_xy   = 1'b0;
      hold_seen = 1'b0;
    end else begin
      if (pend_xy) begin
        chk("alu_x", 32'(alu_x), 32'(px));
        chk("alu_y", 32'(alu_y), 32'(py));
        xy_log.push_back({alu_x, alu_y});
        pend_xy = 1'b0;
      end
      if (hold_seen) begin
        chk("hold_ret_rd", 32'(ret_rd), 32'(h_rd));
        chk("hold_ret_data", 32'(ret_data), 32'(h_data));
        chk("hold_alu_x", 32'(alu_x), 32'(h_x));
        chk("hold_alu_y", 32'(alu_y), 32'(h_y));
        hold_seen = 1'b0;
      end
      if (ret_valid && !ret_ready) begin
        chk("hold_in_ready", 32'(in_ready), 32'(0));
        h_rd = ret_rd; h_data = ret_data; h_x = alu_x; h_y = alu_y;
        hold_seen = 1'b1;
      end
      if (ret_valid && ret_ready) begin
        obs_t e;
        got_q.push_back('{rd: ret_rd, data: ret_data});
        if (exp_q.size() == 0) begin
          chk("ret_unexpected", 32'(ret_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("ret_rd", 32'(ret_rd), 32'(e.rd));
          chk("ret_data", 32'(ret_data), 32'(e.data));
        end
      end
      if (in_valid && in_ready) begin
        logic [WIDTH-1:0] x, y, r;
        x = (in_rs == '0) ? '0 : mreg[in_rs];
        y = in_imm_sel ? in_imm : ((in_rt == '0) ? '0 : mreg[in_rt]);
        r = ref_alu(in_op, x, y);
        exp_q.push_back('{rd: in_rd, data: r});
        if (in_rd != '0) mreg[in_rd] = r;
        px = x; py = y; pend_xy = 1'b1;
      end
    end
  end

  // Called and returns at posedge+#1.
  task automatic issue(input logic [OPW-1:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic sel, input logic [WIDTH-1:0] imm);
    int budget;
    budget = 0;
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm_sel = sel; in_imm = imm;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      budget++;
    end while (!in_ready && budget < 50);
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs;
    logic [AW-1:0]    rt;
    logic             sel;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] ex;
    logic [WIDTH-1:0] ey;
    logic [WIDTH-1:0] ed;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{ALU_ADD,   4'd1, 4'd0, 4'd0, 1'b1, 16'd5,      16'd0,  16'd5,  16'd5};
    tbl[1] = '{ALU_ADD,   4'd2, 4'd1, 4'd0, 1'b1, 16'd3,      16'd5,  16'd3,  16'd8};
    tbl[2] = '{ALU_ADD,   4'd3, 4'd2, 4'd2, 1'b0, 16'd0,      16'd8,  16'd8,  16'd16};
    tbl[3] = '{ALU_SUB,   4'd6, 4'd3, 4'd1, 1'b0, 16'd0,      16'd16, 16'd5,  16'd11};
    tbl[4] = '{ALU_PASSB, 4'd0, 4'd0, 4'd0, 1'b1, 16'd7,      16'd0,  16'd7,  16'd7};
    tbl[5] = '{ALU_ADD,   4'd5, 4'd0, 4'd0, 1'b0, 16'd0,      16'd0,  16'd0,  16'd0};
    tbl[6] = '{ALU_XOR,   4'd7, 4'd6, 4'd0, 1'b1, 16'h00ff,   16'd11, 16'hff, 16'hf4};
    tbl[7] = '{ALU_ADD,   4'd8, 4'd6, 4'd7, 1'b1, 16'd1,      16'd11, 16'd1,  16'd12};

    in_valid = 0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0;
    in_imm_sel = 0; in_imm = '0; ret_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    @(negedge clk);
    chk("rst_alu_x", 32'(alu_x), 32'(0));
    chk("rst_alu_y", 32'(alu_y), 32'(0));
    chk("rst_ret_valid", 32'(ret_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;

    // Directed back-to-back table
    got_q.delete(); xy_log.delete();
    for (int i = 0; i < 8; i++)
      issue(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].sel, tbl[i].imm);
    repeat (4) begin @(posedge clk); #1; end
    chk("tbl_ret_count", 32'(got_q.size()), 32'(8));
    chk("tbl_xy_count", 32'(xy_log.size()), 32'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("tbl%0d_rd", i), 32'(got_q[i].rd), 32'(tbl[i].rd));
        chk($sformatf("tbl%0d_data", i), 32'(got_q[i].data), 32'(tbl[i].ed));
      end
      if (i < xy_log.size()) begin
        chk($sformatf("tbl%0d_xy", i), 32'(xy_log[i]), {tbl[i].ex, tbl[i].ey});
      end
    end

    // Backpressure with a dependent op waiting
    got_q.delete();
    ret_ready = 1'b0;
    issue(ALU_ADD, 4'd4, 4'd3, 4'd0, 1'b1, 16'd1);
    issue(ALU_ADD, 4'd5, 4'd4, 4'd4, 1'b0, 16'd0);
    in_op = ALU_ADD; in_rd = 4'd4; in_rs = 4'd5; in_rt = 4'd4; in_imm_sel = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
    end
    ret_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("stall_ret_count", 32'(got_q.size()), 32'(3));
    if (got_q.size() == 3) begin
      chk("stall_r4a", 32'(got_q[0].data), 32'(17));
      chk("stall_r5", 32'(got_q[1].data), 32'(34));
      chk("stall_r4b_rd", 32'(got_q[2].rd), 32'(4));
      chk("stall_r4b", 32'(got_q[2].data), 32'(51));
    end

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(3) != 0);
      in_op      = OPW'($urandom_range(5));
      in_rd      = AW'($urandom_range(7));
      in_rs      = AW'($urandom_range(7));
      in_rt      = AW'($urandom_range(7));
      in_imm_sel = 1'($urandom_range(1));
      in_imm     = WIDTH'($urandom);
      ret_ready  = ($urandom_range(3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; ret_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("rand_drain", 32'(exp_q.size()), 32'(0));

    // Reset with I and W both occupied
    ret_ready = 1'b0;
    issue(ALU_ADD, 4'd9, 4'd0, 4'd0, 1'b1, 16'h1234);
    issue(ALU_PASSB, 4'd10, 4'd0, 4'd0, 1'b1, 16'h0055);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; ret_ready = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", 32'(in_ready), 32'(1));
    chk("mrst_ret_valid", 32'(ret_valid), 32'(0));
    chk("mrst_alu_x", 32'(alu_x), 32'(0));
    chk("mrst_alu_y", 32'(alu_y), 32'(0));
    chk("mrst_alu_op", 32'(alu_op), 32'(0));
    chk("mrst_ret_rd", 32'(ret_rd), 32'(0));
    chk("mrst_ret_data", 32'(ret_data), 32'(0));
    @(posedge clk); #1;
    got_q.delete(); xy_log.delete();
    issue(ALU_ADD, 4'd11, 4'd9, 4'd10, 1'b0, 16'd0);
    issue(ALU_ADD, 4'd12, 4'd0, 4'd0, 1'b1, 16'd9);
    repeat (4) begin @(posedge clk); #1; end
    chk("mrst_count", 32'(got_q.size()), 32'(2));
    if (got_q.size() == 2) begin
      chk("mrst_r11", 32'(got_q[0].data), 32'(0));
      chk("mrst_r12", 32'(got_q[1].data), 32'(9));
    end
    if (xy_log.size() >= 1) chk("mrst_xy", 32'(xy_log[0]), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
